pulse_event_fifo: RTL and testbench

Parametrised successor of the two-channel alpha/gamma pulse counter. NCH independent threshold/peak detectors feed one shared event FIFO through a round-robin arbiter. Each record holds an absolute (not delta) timestamp. Each channel has a one-entry holding register, so detection never stalls while the FIFO is busy. Sits between the HPF/delay stage and the system-bus register file, which pops records through a valid/ready handshake.

---
 rtl/pulse_event_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_pulse_event_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_fifo.sv
// Multi-channel threshold/peak pulse detector. Each channel parks finished pulses in a
// one-entry holding register; a round-robin arbiter moves them into a shared FWFT event FIFO.
module pulse_event_fifo #(
  parameter int NCH   = 2,
  parameter int DW    = 14,
  parameter int TW    = 32,
  parameter int WW    = 16,
  parameter int DEPTH = 256,
  parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [NCH*DW-1:0]      dat_i,
  input  logic [NCH*DW-1:0]      thresh_i,
  input  logic [NCH-1:0]         sign_i,
  input  logic [NCH*WW-1:0]      mintime_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [CW-1:0]          evt_ch_o,
  output logic [DW-1:0]          evt_amp_o,
  output logic [TW-1:0]          evt_t0_o,
  output logic [WW-1:0]          evt_width_o,
  output logic                   evt_sat_o,
  output logic [31:0]            lost_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [$clog2(DEPTH):0] max_level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = CW + DW + TW + WW + 1;
  localparam logic [WW-1:0] WMAX = '1;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t               r_state [NCH];
  logic signed [DW-1:0] r_sreg  [NCH];
  logic signed [DW-1:0] r_peak  [NCH];
  logic [TW-1:0]        r_t0    [NCH];
  logic [WW-1:0]        r_width [NCH];
  logic [NCH-1:0]       r_sat;
  logic [NCH-1:0]       r_hold_v;
  logic [RW-1:0]        r_hold  [NCH];
  logic [RW-1:0]        r_mem   [DEPTH];
  logic [TW-1:0]        r_ts;
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;
  logic [LW-1:0]        r_max_level;
  logic [31:0]          r_lost;
  logic [CW-1:0]        r_ptr;

  logic [NCH-1:0]       w_over;
  logic [NCH-1:0]       w_emit;
  logic [NCH-1:0]       w_free;
  logic                 w_gnt_v;
  logic [CW-1:0]        w_gnt_idx;
  logic [CW-1:0]        w_cand;
  logic                 w_push;
  logic                 w_pop;
  logic [31:0]          w_drop_cnt;
  logic [RW-1:0]        w_head;

  always_comb begin
    w_over = '0;
    w_emit = '0;
    for (int c = 0; c < NCH; c++) begin
      w_over[c] = sign_i[c] ? (r_sreg[c] <= $signed(thresh_i[c*DW +: DW]))
                            : (r_sreg[c] >= $signed(thresh_i[c*DW +: DW]));
      w_emit[c] = en_i && (r_state[c] == S_ACTIVE) && !w_over[c]
                  && (r_width[c] >= mintime_i[c*WW +: WW]);
    end
  end

  // Round-robin search starts at r_ptr, the channel after the last grant.
  always_comb begin
    w_gnt_v    = 1'b0;
    w_gnt_idx  = '0;
    w_cand     = '0;
    w_free     = '0;
    w_drop_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cand = CW'((int'(r_ptr) + i) % NCH);
      if (!w_gnt_v && r_hold_v[w_cand]) begin
        w_gnt_v   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_push = w_gnt_v && (r_level < LW'(DEPTH));
    w_pop  = evt_valid_o && evt_ready_i;
    for (int c = 0; c < NCH; c++) begin
      w_free[c] = !r_hold_v[c] || (w_push && (w_gnt_idx == CW'(c)));
      if (w_emit[c] && !w_free[c]) w_drop_cnt = w_drop_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NCH; c++) r_sreg[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) r_sreg[c] <= $signed(dat_i[c*DW +: DW]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sat <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_state[c] <= S_IDLE;
        r_peak[c]  <= '0;
        r_t0[c]    <= '0;
        r_width[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clr_i || !en_i) begin
          r_state[c] <= S_IDLE;
        end else begin
          case (r_state[c])
            S_IDLE: if (w_over[c]) begin
              r_state[c] <= S_ACTIVE;
              r_t0[c]    <= r_ts;
              r_peak[c]  <= r_sreg[c];
              r_width[c] <= WW'(1);
              r_sat[c]   <= 1'b0;
            end
            S_ACTIVE: if (w_over[c]) begin
              if (r_width[c] == WMAX) r_sat[c] <= 1'b1;
              else                    r_width[c] <= r_width[c] + 1'b1;
              if (sign_i[c] ? (r_sreg[c] < r_peak[c]) : (r_sreg[c] > r_peak[c]))
                r_peak[c] <= r_sreg[c];
            end else begin
              r_state[c] <= S_IDLE;
            end
            default: r_state[c] <= S_IDLE;
          endcase
        end
      end
    end
  end

  // A hold being drained this cycle may be refilled on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_v <= '0;
      for (int c = 0; c < NCH; c++) r_hold[c] <= '0;
    end else if (clr_i) begin
      r_hold_v <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_emit[c] && w_free[c]) begin
          r_hold_v[c] <= 1'b1;
          r_hold[c]   <= {CW'(c), r_peak[c], r_t0[c], r_width[c], r_sat[c]};
        end else if (w_push && (w_gnt_idx == CW'(c))) begin
          r_hold_v[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= r_hold[w_gnt_idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ts        <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_max_level <= '0;
      r_lost      <= '0;
      r_ptr       <= '0;
    end else if (clr_i) begin
      r_ts        <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_max_level <= '0;
      r_lost      <= '0;
      r_ptr       <= '0;
    end else begin
      if (en_i) r_ts <= r_ts + 1'b1;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_ptr  <= (w_gnt_idx == CW'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (r_level > r_max_level) r_max_level <= r_level;
      if (w_drop_cnt != '0)
        r_lost <= (r_lost > ~w_drop_cnt) ? '1 : r_lost + w_drop_cnt;
    end
  end

  assign w_head      = r_mem[r_rptr];
  assign evt_valid_o = (r_level != '0);
  assign {evt_ch_o, evt_amp_o, evt_t0_o, evt_width_o, evt_sat_o} = evt_valid_o ? w_head : '0;
  assign lost_o      = r_lost;
  assign level_o     = r_level;
  assign max_level_o = r_max_level;

endmodule

// File: tb/tb_pulse_event_fifo.sv
// Directed bench for pulse_event_fifo (NCH=2, WW=4, DEPTH=4) with hand-computed expectations.
module tb_pulse_event_fifo;

  logic        clk = 1'b0;
  logic        rst, clr, en, ready;
  logic [27:0] dat, thresh;
  logic [1:0]  sgn;
  logic [7:0]  mintime;
  logic        evt_valid, evt_sat;
  logic [0:0]  evt_ch;
  logic [13:0] evt_amp;
  logic [31:0] evt_t0, lost;
  logic [3:0]  evt_width;
  logic [2:0]  level, max_level;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] tb_ts = 0;

  always #5 clk = ~clk;

  pulse_event_fifo #(.NCH(2), .DW(14), .TW(32), .WW(4), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .dat_i(dat), .thresh_i(thresh),
    .sign_i(sgn), .mintime_i(mintime), .evt_valid_o(evt_valid), .evt_ready_i(ready),
    .evt_ch_o(evt_ch), .evt_amp_o(evt_amp), .evt_t0_o(evt_t0), .evt_width_o(evt_width),
    .evt_sat_o(evt_sat), .lost_o(lost), .level_o(level), .max_level_o(max_level)
  );

  // Timestamp reference: cleared by reset/clear, advances on each enabled edge.
  task automatic tick();
    @(posedge clk);
    if (rst || clr) tb_ts = 0;
    else if (en)    tb_ts = tb_ts + 1;
    #1;
  endtask

  task automatic put(input int s0, input int s1);
    logic [13:0] a0, a1;
    a0 = s0[13:0];
    a1 = s1[13:0];
    dat = {a1, a0};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0d expected 0", evt_valid); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", level); end
    rst = 1'b0;
    tick();
    n_vec++; if (lost !== 32'd0) begin n_err++; $display("FAIL rst_lost: got %0d expected 0", lost); end
    n_vec++; if (max_level !== 3'd0) begin n_err++; $display("FAIL rst_max: got %0d expected 0", max_level); end
    n_vec++; if ({evt_ch, evt_amp, evt_t0, evt_width, evt_sat} !== 52'd0) begin
      n_err++; $display("FAIL rst_fields: got %h expected 0", {evt_ch, evt_amp, evt_t0, evt_width, evt_sat});
    end
  endtask

  task automatic test_single_pulse();
    logic [31:0] t0e;
    put(0, 0); put(150, 0); t0e = tb_ts;
    put(300, 0); put(200, 0); put(50, 0);
    put(0, 0);
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %0d expected 0", evt_valid); end
    put(0, 0);
    n_vec++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0d expected 1", evt_valid); end
    n_vec++; if (evt_ch !== 1'b0) begin n_err++; $display("FAIL single_ch: got %0d expected 0", evt_ch); end
    n_vec++; if (evt_amp !== 14'd300) begin n_err++; $display("FAIL single_amp: got %0d expected 300", $signed(evt_amp)); end
    n_vec++; if (evt_width !== 4'd3) begin n_err++; $display("FAIL single_width: got %0d expected 3", evt_width); end
    n_vec++; if (evt_sat !== 1'b0) begin n_err++; $display("FAIL single_sat: got %0d expected 0", evt_sat); end
    n_vec++; if (evt_t0 !== t0e) begin n_err++; $display("FAIL single_t0: got %0d expected %0d", evt_t0, t0e); end
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d expected 1", level); end
    ready = 1'b1; put(0, 0); ready = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL single_pop: got %0d expected 0", level); end
  endtask

  task automatic test_mintime_reject();
    put(0, 0); put(150, 0); put(300, 0); put(50, 0);
    put(0, 0); put(0, 0); put(0, 0);
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reject_level: got %0d expected 0", level); end
    n_vec++; if (lost !== 32'd0) begin n_err++; $display("FAIL reject_lost: got %0d expected 0", lost); end
  endtask

  task automatic test_negative();
    logic [31:0] t0e;
    thresh = {-14'sd100, 14'sd100};
    sgn = 2'b10;
    mintime = {4'd1, 4'd3};
    put(0, -50); put(0, -200); t0e = tb_ts;
    put(0, -500); put(0, -120); put(0, 0);
    put(0, 0); put(0, 0);
    n_vec++; if (evt_ch !== 1'b1) begin n_err++; $display("FAIL neg_ch: got %0d expected 1", evt_ch); end
    n_vec++; if (evt_amp !== -14'sd500) begin n_err++; $display("FAIL neg_amp: got %0d expected -500", $signed(evt_amp)); end
    n_vec++; if (evt_width !== 4'd3) begin n_err++; $display("FAIL neg_width: got %0d expected 3", evt_width); end
    n_vec++; if (evt_t0 !== t0e) begin n_err++; $display("FAIL neg_t0: got %0d expected %0d", evt_t0, t0e); end
    ready = 1'b1; put(0, 0); ready = 1'b0;
    thresh = {14'sd100, 14'sd100};
    sgn = 2'b00;
    mintime = {4'd3, 4'd3};
  endtask

  task automatic pair_pulse(input logic m0, input logic m1);
    put(0, 0);
    put(m0 ? 150 : 0, m1 ? 150 : 0);
    put(m0 ? 300 : 0, m1 ? 300 : 0);
    put(m0 ? 200 : 0, m1 ? 200 : 0);
    put(m0 ? 50 : 0, m1 ? 50 : 0);
    put(0, 0); put(0, 0);
  endtask

  task automatic test_simultaneous();
    pair_pulse(1'b1, 1'b1);
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL sim_level1: got %0d expected 1", level); end
    n_vec++; if (evt_ch !== 1'b0) begin n_err++; $display("FAIL sim_first_ch: got %0d expected 0", evt_ch); end
    put(0, 0);
    n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL sim_level2: got %0d expected 2", level); end
    ready = 1'b1; put(0, 0);
    n_vec++; if (evt_ch !== 1'b1) begin n_err++; $display("FAIL sim_second_ch: got %0d expected 1", evt_ch); end
    put(0, 0); ready = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL sim_drain: got %0d expected 0", level); end
  endtask

  task automatic test_round_robin();
    pair_pulse(1'b1, 1'b0);
    ready = 1'b1; put(0, 0); ready = 1'b0;
    pair_pulse(1'b1, 1'b1);
    n_vec++; if (evt_ch !== 1'b1) begin n_err++; $display("FAIL rr_first_ch: got %0d expected 1", evt_ch); end
    put(0, 0);
    ready = 1'b1; put(0, 0);
    n_vec++; if (evt_ch !== 1'b0) begin n_err++; $display("FAIL rr_second_ch: got %0d expected 0", evt_ch); end
    put(0, 0); ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] t0e [6];
    logic [31:0] prev;
    for (int k = 0; k < 6; k++) begin
      put(150, 0); t0e[k] = tb_ts;
      put(150, 0); put(150, 0);
      put(0, 0); put(0, 0); put(0, 0);
    end
    put(0, 0); put(0, 0);
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d expected 4", level); end
    n_vec++; if (lost !== 32'd1) begin n_err++; $display("FAIL ovf_lost: got %0d expected 1", lost); end
    n_vec++; if (max_level !== 3'd4) begin n_err++; $display("FAIL ovf_max: got %0d expected 4", max_level); end
    prev = 0;
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid%0d: got %0d expected 1", k, evt_valid); end
      n_vec++; if (evt_t0 !== t0e[k]) begin n_err++; $display("FAIL ovf_t0_%0d: got %0d expected %0d", k, evt_t0, t0e[k]); end
      if (k > 0) begin
        n_vec++; if (evt_t0 <= prev) begin n_err++; $display("FAIL ovf_order%0d: got %0d expected above %0d", k, evt_t0, prev); end
      end
      prev = evt_t0;
      put(0, 0);
    end
    ready = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL ovf_drain: got %0d expected 0", level); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) put(150, 0);
    put(0, 0); put(0, 0); put(0, 0);
    n_vec++; if (evt_width !== 4'd15) begin n_err++; $display("FAIL sat_width: got %0d expected 15", evt_width); end
    n_vec++; if (evt_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %0d expected 1", evt_sat); end
    ready = 1'b1; put(0, 0); ready = 1'b0;
  endtask

  task automatic test_enable();
    put(150, 0); put(150, 0);
    en = 1'b0; put(150, 0);
    en = 1'b1; put(150, 0);
    put(0, 0); put(0, 0); put(0, 0); put(0, 0);
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL en_discard: got %0d expected 0", level); end
  endtask

  task automatic test_clear();
    put(150, 0); put(150, 0); put(150, 0);
    put(0, 0); put(0, 0); put(0, 0);
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL clr_pre: got %0d expected 1", level); end
    for (int k = 0; k < 4; k++) put(150, 0);
    clr = 1'b1; put(0, 0); clr = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL clr_level: got %0d expected 0", level); end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %0d expected 0", evt_valid); end
    n_vec++; if (lost !== 32'd0) begin n_err++; $display("FAIL clr_lost: got %0d expected 0", lost); end
    n_vec++; if (max_level !== 3'd0) begin n_err++; $display("FAIL clr_max: got %0d expected 0", max_level); end
    put(150, 0); put(150, 0); put(150, 0);
    put(0, 0); put(0, 0); put(0, 0);
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL clr_cut: got %0d expected 1", level); end
    n_vec++; if (evt_t0 !== 32'd1) begin n_err++; $display("FAIL clr_t0: got %0d expected 1", evt_t0); end
    n_vec++; if (evt_width !== 4'd3) begin n_err++; $display("FAIL clr_width: got %0d expected 3", evt_width); end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b1; ready = 1'b0;
    dat = '0;
    thresh = {14'sd100, 14'sd100};
    sgn = 2'b00;
    mintime = {4'd3, 4'd3};
    test_reset();
    test_single_pulse();
    test_mintime_reject();
    test_negative();
    test_simultaneous();
    test_round_robin();
    test_overflow();
    test_saturation();
    test_enable();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
